// File: rtl/fix_msg_serializer.sv
// Serializes FIX field commands into ASCII "tag=value<SOH>" bytes and closes each message with a "10=NNN<SOH>" checksum trailer.
// Latency: the first byte of an accepted command appears on dout the next cycle, and bytes then stream at one per cycle.
// Backpressure: the byte register advances only when !valid || out_ready; while it is stalled, no input handshake completes.
module fix_msg_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        fld_valid,
    output logic        fld_ready,
    input  logic [13:0] fld_tag,
    input  logic        fld_trailer,
    input  logic        val_valid,
    output logic        val_ready,
    input  logic [7:0]  val_data,
    input  logic        val_last,
    output logic [7:0]  dout,
    output logic        valid,
    input  logic        out_ready,
    output logic        msg_done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_EQ,
        S_VAL,
        S_SOH,
        S_CK_TAG,
        S_CK_DIG,
        S_CK_SOH
    } state_t;

    localparam logic [7:0] SOH_BYTE = 8'h01;
    localparam logic [7:0] EQ_BYTE  = 8'h3D;
    localparam logic [7:0] SUB_BYTE = 8'h3F;

    state_t      state;
    logic [3:0]  tag_dig [0:4];   // index 0 holds the ten-thousands digit and index 4 holds the ones digit
    logic [2:0]  idx;             // position within the digit sequence currently being emitted
    logic [7:0]  cksum;
    logic        trl_soh;         // dout holds the SOH byte that closes a trailer

    logic        adv;
    logic        fld_acc;
    logic        val_acc;
    logic [7:0]  cksum_base;
    logic [7:0]  val_byte;
    logic [3:0]  nd [0:4];
    logic [2:0]  start;
    logic [3:0]  ck_h;
    logic [3:0]  ck_t;
    logic [3:0]  ck_o;

    function automatic logic [7:0] asc(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Compute the handshake and pulse outputs. The reset term holds fld_ready low while reset is asserted.
    always_comb begin
        adv        = !valid || out_ready;
        fld_ready  = reset && (state == S_IDLE) && adv;
        val_ready  = reset && (state == S_VAL) && adv;
        fld_acc    = fld_valid && fld_ready;
        val_acc    = val_valid && val_ready;
        err        = val_acc && (val_data == SOH_BYTE);
        msg_done   = valid && out_ready && trl_soh;
        cksum_base = msg_done ? 8'h00 : cksum;
        val_byte   = (val_data == SOH_BYTE) ? SUB_BYTE : val_data;
    end

    // Split the incoming tag into decimal digits and find the first significant digit.
    always_comb begin
        nd[0] = 4'(fld_tag / 14'd10000);
        nd[1] = 4'((fld_tag / 14'd1000) % 14'd10);
        nd[2] = 4'((fld_tag / 14'd100) % 14'd10);
        nd[3] = 4'((fld_tag / 14'd10) % 14'd10);
        nd[4] = 4'(fld_tag % 14'd10);
        if (fld_tag >= 14'd10000)     start = 3'd0;
        else if (fld_tag >= 14'd1000) start = 3'd1;
        else if (fld_tag >= 14'd100)  start = 3'd2;
        else if (fld_tag >= 14'd10)   start = 3'd3;
        else                          start = 3'd4;
    end

    // The checksum stays constant during a trailer, so its digits can be derived from it directly.
    always_comb begin
        ck_h = 4'(cksum / 8'd100);
        ck_t = 4'((cksum / 8'd10) % 8'd10);
        ck_o = 4'(cksum % 8'd10);
    end

    // Sequence the FSM and the output byte register. Every byte loaded outside a trailer is added to the checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            tag_dig <= '{default: 4'h0};
            idx     <= 3'd0;
            cksum   <= 8'h00;
            trl_soh <= 1'b0;
            dout    <= 8'h00;
            valid   <= 1'b0;
        end else begin
            if (msg_done) begin
                cksum <= 8'h00;
            end
            if (adv) begin
                trl_soh <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (fld_acc) begin
                            valid <= 1'b1;
                            idx   <= 3'd0;
                            if (fld_trailer) begin
                                dout  <= 8'h31;
                                state <= S_CK_TAG;
                            end else begin
                                dout    <= asc(nd[start]);
                                cksum   <= cksum_base + asc(nd[start]);
                                tag_dig <= nd;
                                idx     <= start + 3'd1;
                                state   <= (start == 3'd4) ? S_EQ : S_TAG;
                            end
                        end else begin
                            valid <= 1'b0;
                        end
                    end
                    S_TAG: begin
                        valid <= 1'b1;
                        dout  <= asc(tag_dig[idx]);
                        cksum <= cksum_base + asc(tag_dig[idx]);
                        idx   <= idx + 3'd1;
                        if (idx == 3'd4) state <= S_EQ;
                    end
                    S_EQ: begin
                        valid <= 1'b1;
                        dout  <= EQ_BYTE;
                        cksum <= cksum_base + EQ_BYTE;
                        state <= S_VAL;
                    end
                    S_VAL: begin
                        // When no value byte is available, the register drains and no filler byte is emitted.
                        if (val_acc) begin
                            valid <= 1'b1;
                            dout  <= val_byte;
                            cksum <= cksum_base + val_byte;
                            if (val_last) state <= S_SOH;
                        end else begin
                            valid <= 1'b0;
                        end
                    end
                    S_SOH: begin
                        valid <= 1'b1;
                        dout  <= SOH_BYTE;
                        cksum <= cksum_base + SOH_BYTE;
                        state <= S_IDLE;
                    end
                    S_CK_TAG: begin
                        valid <= 1'b1;
                        if (idx == 3'd0) begin
                            dout <= 8'h30;
                            idx  <= 3'd1;
                        end else begin
                            dout  <= EQ_BYTE;
                            idx   <= 3'd0;
                            state <= S_CK_DIG;
                        end
                    end
                    S_CK_DIG: begin
                        valid <= 1'b1;
                        idx   <= idx + 3'd1;
                        case (idx)
                            3'd0:    dout <= asc(ck_h);
                            3'd1:    dout <= asc(ck_t);
                            default: begin
                                dout  <= asc(ck_o);
                                state <= S_CK_SOH;
                            end
                        endcase
                    end
                    S_CK_SOH: begin
                        valid   <= 1'b1;
                        dout    <= SOH_BYTE;
                        trl_soh <= 1'b1;
                        state   <= S_IDLE;
                    end
                    default: begin
                        valid <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
